// File: rtl/gf1024_mul.sv
// gf1024_mul -- GF(2^W) multiplier, polynomial basis (default GF(2^10),
// x^10 + x^3 + 1). This is the shared product primitive of the RS decoder
// datapath.
//
// Ports:
//   clk_i   in   1  clock, rising edge
//   rst_ni  in   1  synchronous active-low reset (registered path only)
//   a, b    in   W  operands, bit i = coefficient of x^i
//   p       out  W  combinational product a*b mod POLY (zero latency)
//   vld_i   in   1  qualifies a/b for the registered path
//   p_q     out  W  registered product, one cycle after vld_i
//   vld_o   out  1  p_q valid flag
module gf1024_mul #(
  parameter int         W    = 10,
  parameter logic [W:0] POLY = 11'h409
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  input  logic         vld_i,
  output logic [W-1:0] p_q,
  output logic         vld_o
);

  localparam int PW = 2 * W - 1;

  // Carry-less product: XOR of shifted copies of x, each gated by a bit of y.
  function automatic logic [PW-1:0] clmul(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      acc = acc ^ (({{(W-1){1'b0}}, x} & {PW{y[i]}}) << i);
    end
    return acc;
  endfunction

  // Reduce modulo POLY, cancelling the highest bit first so each step only
  // touches bits below the one it clears.
  function automatic logic [W-1:0] reduce(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = v;
    for (int k = PW - 1; k >= W; k--) begin
      r = r ^ (({{(W-2){1'b0}}, POLY} & {PW{r[k]}}) << (k - W));
    end
    return r[W-1:0];
  endfunction

  // Stage 0: combinational product
  logic [W-1:0] prod_p0;

  always_comb begin
    prod_p0 = reduce(clmul(a, b));
  end

  assign p = prod_p0;

  // Stage 1: registered product; holds when no valid operand arrives
  logic [W-1:0] prod_p1;
  logic         vld_p1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
    end else begin
      vld_p1 <= vld_i;
      if (vld_i) begin
        prod_p1 <= prod_p0;
      end
    end
  end

  assign p_q   = prod_p1;
  assign vld_o = vld_p1;

endmodule

// File: tb/tb_gf1024_mul.sv
// tb_gf1024_mul -- self-checking bench for gf1024_mul: directed boundary
// products, exhaustive identity sweep, random algebraic identities against a
// bit-serial (Horner, multiply-by-x) reference, and the registered path with
// reset and vld_i gaps.
module tb_gf1024_mul;

  logic       clk_i;
  logic       rst_ni;
  logic [9:0] a;
  logic [9:0] b;
  logic [9:0] p;
  logic       vld_i;
  logic [9:0] p_q;
  logic       vld_o;

  int n_vec;
  int n_err;

  // Expected registered-path state
  logic [9:0] exp_pq;
  logic       exp_vld;

  gf1024_mul #(.W(10), .POLY(11'h409)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .a     (a),
    .b     (b),
    .p     (p),
    .vld_i (vld_i),
    .p_q   (p_q),
    .vld_o (vld_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Bit-serial reference: Horner over y's bits, multiplying by x each step
  // and folding x^10 back as x^3 + 1.
  function automatic logic [9:0] gmul(input logic [9:0] x, input logic [9:0] y);
    logic [10:0] r;
    r = '0;
    for (int i = 9; i >= 0; i--) begin
      r = r << 1;
      if (r[10]) r = r ^ 11'h409;
      if (y[i]) r[9:0] = r[9:0] ^ x;
    end
    return r[9:0];
  endfunction

  task automatic check_eq(input string tag, input logic [9:0] act,
                          input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, act, exp);
    end
  endtask

  // Drive operands and return the combinational product.
  task automatic apply(input logic [9:0] x, input logic [9:0] y,
                       output logic [9:0] r);
    a = x;
    b = y;
    #1;
    r = p;
  endtask

  task automatic comb_chk(input string tag, input logic [9:0] x,
                          input logic [9:0] y, input logic [9:0] exp);
    logic [9:0] r;
    apply(x, y, r);
    check_eq(tag, r, exp);
  endtask

  // One clock of the registered path: check outputs from the previous edge,
  // drive new inputs, check live p, and advance the expected state.
  task automatic cycle(input string tag, input logic rst, input logic vld,
                       input logic [9:0] x, input logic [9:0] y);
    @(negedge clk_i);
    check_eq({tag, "_vld"}, {9'd0, vld_o}, {9'd0, exp_vld});
    check_eq({tag, "_pq"}, p_q, exp_pq);
    rst_ni = rst;
    vld_i  = vld;
    a      = x;
    b      = y;
    #1;
    check_eq({tag, "_p"}, p, gmul(x, y));
    if (!rst) begin
      exp_vld = 1'b0;
      exp_pq  = '0;
    end else begin
      exp_vld = vld;
      if (vld) exp_pq = gmul(x, y);
    end
  endtask

  initial begin
    logic [9:0] ra, rb, rc, r1, r2, r3;
    n_vec  = 0;
    n_err  = 0;
    rst_ni = 1'b0;
    vld_i  = 1'b1;
    a      = 10'h123;
    b      = 10'h045;
    exp_vld = 1'b0;
    exp_pq  = '0;
    @(posedge clk_i);

    // Reset held with valid operands present; p stays live.
    for (int i = 0; i < 3; i++) cycle("reset", 1'b0, 1'b1, 10'h123, 10'h045);
    cycle("reset_exit", 1'b1, 1'b0, 10'h123, 10'h045);

    // Reduction boundaries and an inverse pair.
    comb_chk("x9_x1", 10'h200, 10'h002, 10'h009);
    comb_chk("x9_x9", 10'h200, 10'h200, 10'h112);
    comb_chk("all1_one", 10'h3FF, 10'h001, 10'h3FF);
    comb_chk("zero_all1", 10'h000, 10'h3FF, 10'h000);
    comb_chk("inverse", 10'h002, 10'h204, 10'h001);

    // Identity and annihilator sweeps.
    for (int i = 0; i < 1024; i++) begin
      comb_chk("one_sweep", 10'(i), 10'h001, 10'(i));
      comb_chk("zero_sweep", 10'h000, 10'(i), 10'h000);
    end

    // Random triples: product, commutativity, associativity, distributivity.
    for (int i = 0; i < 10000; i++) begin
      ra = 10'($urandom());
      rb = 10'($urandom());
      rc = 10'($urandom());
      apply(ra, rb, r1);
      check_eq("rand_ab", r1, gmul(ra, rb));
      apply(rb, ra, r2);
      check_eq("rand_comm", r2, r1);
      apply(r1, rc, r3);
      check_eq("rand_assoc", r3, gmul(ra, gmul(rb, rc)));
      apply(ra, rb ^ rc, r3);
      check_eq("rand_dist", r3, gmul(ra, rb) ^ gmul(ra, rc));
    end

    // Registered pipeline: vld pattern 1,1,0,1 then idle.
    cycle("pipe0", 1'b1, 1'b1, 10'h0A5, 10'h13C);
    cycle("pipe1", 1'b1, 1'b1, 10'h2F1, 10'h077);
    cycle("pipe2", 1'b1, 1'b0, 10'h155, 10'h2AA);
    cycle("pipe3", 1'b1, 1'b1, 10'h3E0, 10'h019);
    cycle("pipe4", 1'b1, 1'b0, 10'h001, 10'h001);
    cycle("pipe5", 1'b1, 1'b0, 10'h001, 10'h001);

    // Reset mid-stream with vld_i high, then resume.
    cycle("mid0", 1'b1, 1'b1, 10'h321, 10'h0FE);
    cycle("mid1", 1'b0, 1'b1, 10'h1AB, 10'h2CD);
    cycle("mid2", 1'b1, 1'b1, 10'h0DE, 10'h3AD);
    cycle("mid3", 1'b1, 1'b0, 10'h000, 10'h000);
    cycle("mid4", 1'b1, 1'b0, 10'h000, 10'h000);

    // Random registered stream with gaps and occasional reset.
    for (int i = 0; i < 300; i++) begin
      cycle("stream", ($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0),
            10'($urandom()), 10'($urandom()));
    end
    cycle("stream_end", 1'b1, 1'b0, 10'h000, 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gf1024_mul.md
Name: gf1024_mul

Overview:
- Galois-field multiplier over GF(2^10), polynomial basis; the shared arithmetic primitive of the RS decoder datapath (Forney numerator*phase and pre*inverse products, syndrome/Chien reuse).
- Provides a purely combinational product for in-stage use.
- Also provides a one-cycle registered copy with a valid flag, so pipeline stages can use either form.

Parameters:
- W, 10, field element width in bits; the block is verified only at W=10.
- POLY, 11'h409, primitive polynomial including the x^W term. Default is x^10 + x^3 + 1. Bit W must be 1.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- a  input  W  multiplicand, polynomial basis, bit i = coefficient of x^i.
- b  input  W  multiplier, same encoding.
- p  output  W  combinational product a*b mod POLY.
- vld_i  input  1  qualifies a/b for the registered path.
- p_q  output  W  registered product.
- vld_o  output  1  p_q valid flag.

Behaviour:
- Combinational path, zero latency: p = reduce(clmul(a,b)).
  - clmul is the carry-less (XOR) product, 2W-1 bits wide.
  - reduce repeatedly cancels bit k, for k = 2W-2 down to W, by XOR-ing POLY shifted left by (k-W).
  - p is a pure function of a and b. It has no dependence on clk_i, rst_ni or vld_i, and holds no latch or state.
- Field identities p must satisfy for all inputs:
  - p(0,x) = p(x,0) = 0
  - p(1,x) = x
  - commutative: p(a,b) = p(b,a)
  - associative
  - distributive over XOR
- Registered path, rising edge of clk_i:
  - If rst_ni=0: p_q <= 0, vld_o <= 0.
  - Else: vld_o <= vld_i. If vld_i=1, p_q <= p; otherwise p_q holds its previous value.
  - Latency is exactly 1 cycle. Throughput is one product per cycle; back-to-back vld_i is legal.
  - There is no backpressure. The caller stalls by holding vld_i low.
- Reset behaviour:
  - Reset is synchronous. Asserting rst_ni mid-stream clears p_q and vld_o at the next edge, with no partial state.
  - During reset, the combinational p still tracks a and b.
  - Deassertion needs no recovery cycles. The first edge with rst_ni=1 and vld_i=1 produces vld_o=1 on the following cycle.
- Other requirements:
  - X-free: with a and b known, p must be known. No division, no tables; XOR/AND logic only.
  - Registered-path output equals the combinational result of the previous cycle's operands. The bench checks p_q against a p sampled one cycle earlier.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with vld_i=1, a=0x123, b=0x045 -> p_q=0x000 and vld_o=0 every cycle; p=0x123*0x045 stays live.
- Reduction boundary: a=0x200 (x^9), b=0x002 -> p=0x009; a=0x200, b=0x200 -> p=0x112; a=0x3FF, b=0x001 -> p=0x3FF; a=0x000, b=0x3FF -> p=0x000.
- Inverse pair: a=0x002, b=0x204 -> p=0x001. Exhaustive sweep over a with b=0x001 -> p=a.
- Algebraic random: 10k random triples (a,b,c), compared against a bit-serial software model -> p(a,b)=p(b,a), p(p(a,b),c)=p(a,p(b,c)), p(a,b^c)=p(a,b)^p(a,c).
- Registered pipeline: drive vld_i pattern 1,1,0,1 with a distinct a/b each cycle -> vld_o follows as 0,1,1,0,1; each p_q equals the previous cycle's p; p_q holds its value on the gap cycle.
- Reset mid-stream: rst_ni=0 for one cycle while vld_i=1 -> next cycle vld_o=0 and p_q=0; the following cycle resumes normally.
